// File: rtl/psram_pkg.sv
// ---------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the PSRAM QPI responder: the command opcodes it
// understands and the encoding of its transaction state machine.
// ---------------------------------------------------------------------------
package psram_pkg;

    localparam logic [7:0] CMD_QPI_ENTER = 8'h35;  // SPI: switch to QPI
    localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;  // QPI: back to SPI
    localparam logic [7:0] CMD_QPI_READ  = 8'hEB;  // QPI: quad read with dummy cycles
    localparam logic [7:0] CMD_QPI_WRITE = 8'h38;  // QPI: quad write
    localparam logic [7:0] CMD_RST_EN    = 8'h66;  // arm software reset
    localparam logic [7:0] CMD_RST       = 8'h99;  // software reset (needs arm)
    localparam logic [7:0] CMD_SPI_READ  = 8'h03;  // SPI: serial read (optional)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_IGNORE  = 3'd6
    } state_t;

endpackage

// File: rtl/psram_edge_sync.sv
// ---------------------------------------------------------------------------
// psram_edge_sync
// Two-flop synchronizer for one asynchronous input followed by a rise/fall
// detector on the synchronized level. The detector pulses are one clk wide.
//
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset (flops load RESET_VAL)
//   din   - asynchronous input
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module psram_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
            prev_reg <= RESET_VAL;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/psram_qpi_responder.sv
// ---------------------------------------------------------------------------
// psram_qpi_responder
// Behavioural PSRAM target with an SPI/QPI command front end and a
// 2^ADDR_BITS byte array. All bus inputs are oversampled on clk (>= 4x the
// mem_clk rate); data is sampled on mem_clk rise and launched on mem_clk fall.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset (aborts any transaction)
//   mem_ce_n - chip enable from the initiator, active low
//   mem_clk  - serial clock from the initiator, mode 0
//   mem_sio  - 4-bit bidirectional data bus, high-Z unless driven here
//   qpi_mode - high while the device is in QPI mode
//   busy     - high while a transaction is in progress (state != IDLE)
//
// Build option:
//   PSRAM_RESP_SPI_READ_EN - adds SPI-mode command 0x03 (serial read, data
//                            on sio[1]). Without it 0x03 is ignored.
// ---------------------------------------------------------------------------
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_ce_n,
    input  logic       mem_clk,
    inout  wire  [3:0] mem_sio,
    output logic       qpi_mode,
    output logic       busy
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

    state_t               state_reg, state_next;
    logic                 qpi_reg, qpi_next;
    logic                 arm_reg, arm_next;
    logic                 is_write_reg, is_write_next;
    logic                 spi_rd_reg, spi_rd_next;
    logic                 phase_reg, phase_next;
    logic [6:0]           cmd_reg, cmd_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic [ADDR_BITS-1:0] addr_reg, addr_next;
    logic [3:0]           wr_hi_reg, wr_hi_next;
    logic [3:0]           sio_out_reg, sio_out_next;
    logic [3:0]           oe_reg, oe_next;
    logic [3:0]           sio_meta_reg, sio_sync_reg;
    logic [7:0]           rd_data_reg;

    // Contents come from the configuration image (all zero); no reset port.
    logic [7:0] mem [0:(1<<ADDR_BITS)-1];

    logic                 clk_rise, clk_fall;
    logic                 ce_rise, ce_fall;
    logic                 mem_we;
    logic [7:0]           mem_wdata;
    logic [7:0]           cmd_full;
    logic                 cmd_done;
    logic [ADDR_BITS-1:0] addr_shift;
    logic                 addr_done;
    logic [ADDR_BITS-1:0] addr_inc;

    psram_edge_sync #(.RESET_VAL(1'b0)) u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mem_clk),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    psram_edge_sync #(.RESET_VAL(1'b1)) u_ce_sync (
        .clk   (clk),
        .reset (reset),
        .din   (mem_ce_n),
        .rise  (ce_rise),
        .fall  (ce_fall)
    );

    // Same two-flop latency as mem_clk, so sio_sync_reg is aligned with clk_rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sio_meta_reg <= 4'h0;
            sio_sync_reg <= 4'h0;
        end else begin
            sio_meta_reg <= mem_sio;
            sio_sync_reg <= sio_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sio
            assign mem_sio[gi] = oe_reg[gi] ? sio_out_reg[gi] : 1'bz;
        end
    endgenerate

    // The command and address are shifted straight into their registers, so
    // the value below is the byte/address including the nibble or bit now on
    // the bus. Address bits above ADDR_BITS simply fall off the top.
    assign cmd_full   = qpi_reg ? {cmd_reg[3:0], sio_sync_reg} : {cmd_reg, sio_sync_reg[0]};
    assign cmd_done   = qpi_reg ? (cnt_reg == 8'd1) : (cnt_reg == 8'd7);
    assign addr_shift = spi_rd_reg ? {addr_reg[ADDR_BITS-2:0], sio_sync_reg[0]}
                                   : {addr_reg[ADDR_BITS-5:0], sio_sync_reg};
    assign addr_done  = spi_rd_reg ? (cnt_reg == 8'd23) : (cnt_reg == 8'd5);
    assign addr_inc   = addr_reg + 1'b1;
    assign mem_wdata  = {wr_hi_reg, sio_sync_reg};

    always_comb begin
        state_next    = state_reg;
        qpi_next      = qpi_reg;
        arm_next      = arm_reg;
        is_write_next = is_write_reg;
        spi_rd_next   = spi_rd_reg;
        phase_next    = phase_reg;
        cmd_next      = cmd_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        wr_hi_next    = wr_hi_reg;
        sio_out_next  = sio_out_reg;
        oe_next       = oe_reg;
        mem_we        = 1'b0;

        // A CE rise wins over any mem_clk edge seen in the same cycle.
        if (ce_rise) begin
            state_next = ST_IDLE;
            oe_next    = 4'h0;
            phase_next = 1'b0;
            cnt_next   = 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ce_fall) begin
                        state_next    = ST_CMD;
                        cnt_next      = 8'd0;
                        phase_next    = 1'b0;
                        is_write_next = 1'b0;
                        spi_rd_next   = 1'b0;
                    end
                end

                ST_CMD: begin
                    if (clk_rise) begin
                        cmd_next = cmd_full[6:0];
                        cnt_next = cnt_reg + 8'd1;
                        if (cmd_done) begin
                            cnt_next   = 8'd0;
                            state_next = ST_IGNORE;
                            // Any command other than 0x66 leaves the reset disarmed.
                            arm_next   = (cmd_full == CMD_RST_EN);
                            if (cmd_full == CMD_RST && arm_reg) begin
                                qpi_next = 1'b0;
                            end
                            if (qpi_reg) begin
                                case (cmd_full)
                                    CMD_QPI_READ: begin
                                        state_next    = ST_ADDR;
                                        is_write_next = 1'b0;
                                    end
                                    CMD_QPI_WRITE: begin
                                        state_next    = ST_ADDR;
                                        is_write_next = 1'b1;
                                    end
                                    CMD_QPI_EXIT: qpi_next = 1'b0;
                                    default: ;
                                endcase
                            end else begin
                                if (cmd_full == CMD_QPI_ENTER) begin
                                    qpi_next = 1'b1;
                                end
`ifdef PSRAM_RESP_SPI_READ_EN
                                if (cmd_full == CMD_SPI_READ) begin
                                    state_next    = ST_ADDR;
                                    is_write_next = 1'b0;
                                    spi_rd_next   = 1'b1;
                                end
`endif
                            end
                        end
                    end
                end

                ST_ADDR: begin
                    if (clk_rise) begin
                        addr_next = addr_shift;
                        cnt_next  = cnt_reg + 8'd1;
                        if (addr_done) begin
                            cnt_next = 8'd0;
                            if (is_write_reg) begin
                                state_next = ST_WR_DATA;
                            end else if (spi_rd_reg || WAIT_CYCLES == 0) begin
                                state_next = ST_RD_DATA;
                            end else begin
                                state_next = ST_WAIT;
                            end
                        end
                    end
                end

                ST_WAIT: begin
                    if (clk_rise) begin
                        cnt_next = cnt_reg + 8'd1;
                        if (cnt_reg == WAIT_LAST) begin
                            cnt_next   = 8'd0;
                            state_next = ST_RD_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    // rd_data_reg follows addr_reg one clk later; mem_clk
                    // half periods are long enough for it to settle.
                    if (clk_fall) begin
                        if (spi_rd_reg) begin
                            oe_next      = 4'b0010;
                            sio_out_next = {2'b00, rd_data_reg[3'd7 - cnt_reg[2:0]], 1'b0};
                            cnt_next     = cnt_reg + 8'd1;
                            if (cnt_reg[2:0] == 3'd7) begin
                                cnt_next  = 8'd0;
                                addr_next = addr_inc;
                            end
                        end else begin
                            oe_next = 4'hF;
                            if (!phase_reg) begin
                                sio_out_next = rd_data_reg[7:4];
                                phase_next   = 1'b1;
                            end else begin
                                sio_out_next = rd_data_reg[3:0];
                                phase_next   = 1'b0;
                                addr_next    = addr_inc;
                            end
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (clk_rise) begin
                        if (!phase_reg) begin
                            wr_hi_next = sio_sync_reg;
                            phase_next = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            phase_next = 1'b0;
                            addr_next  = addr_inc;
                        end
                    end
                end

                ST_IGNORE: oe_next = 4'h0;

                default: begin
                    state_next = ST_IDLE;
                    oe_next    = 4'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            qpi_reg      <= 1'b0;
            arm_reg      <= 1'b0;
            is_write_reg <= 1'b0;
            spi_rd_reg   <= 1'b0;
            phase_reg    <= 1'b0;
            cmd_reg      <= 7'd0;
            cnt_reg      <= 8'd0;
            addr_reg     <= '0;
            wr_hi_reg    <= 4'h0;
            sio_out_reg  <= 4'h0;
            oe_reg       <= 4'h0;
        end else begin
            state_reg    <= state_next;
            qpi_reg      <= qpi_next;
            arm_reg      <= arm_next;
            is_write_reg <= is_write_next;
            spi_rd_reg   <= spi_rd_next;
            phase_reg    <= phase_next;
            cmd_reg      <= cmd_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            wr_hi_reg    <= wr_hi_next;
            sio_out_reg  <= sio_out_next;
            oe_reg       <= oe_next;
        end
    end

    // Byte array: single write port, registered read at the current address.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_reg] <= mem_wdata;
        end
        rd_data_reg <= mem[addr_reg];
    end

    assign qpi_mode = qpi_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_psram_qpi_responder.sv
// ---------------------------------------------------------------------------
// tb_psram_qpi_responder
// Bus-level bench: a host model drives SPI/QPI transactions, a byte model
// tracks what was written, and expected read bytes are queued when a read is
// issued and compared when the responder shifts them out. The data bus has
// pull-ups so a released bus reads as all ones.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_psram_qpi_responder;
    import psram_pkg::*;

    localparam int ADDR_BITS   = 10;
    localparam int WAIT_CYCLES = 6;
    localparam int HALF        = 5;     // clk cycles per mem_clk half period

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       mem_ce_n = 1'b1;
    logic       mem_clk  = 1'b0;
    tri1  [3:0] mem_sio;
    logic [3:0] tb_dout  = 4'h0;
    logic [3:0] tb_oe    = 4'h0;
    logic       qpi_mode;
    logic       busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_mem [0:(1<<ADDR_BITS)-1];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_host
            assign mem_sio[gi] = tb_oe[gi] ? tb_dout[gi] : 1'bz;
        end
    endgenerate

    psram_qpi_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_ce_n (mem_ce_n),
        .mem_clk  (mem_clk),
        .mem_sio  (mem_sio),
        .qpi_mode (qpi_mode),
        .busy     (busy)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One mem_clk period: present data, sample the bus just before the rise.
    task automatic mclk_cycle(input logic [3:0] dout, input logic [3:0] doe, output logic [3:0] din);
        tb_dout = dout;
        tb_oe   = doe;
        repeat (HALF) @(posedge clk);
        #1;
        din     = mem_sio;
        mem_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        mem_clk = 1'b0;
    endtask

    task automatic ce_low();
        @(posedge clk);
        #1;
        mem_ce_n = 1'b0;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    // Raise CE after a half period and require the bus to be released and
    // the responder idle three clk later.
    task automatic ce_high(input string tag);
        repeat (HALF) @(posedge clk);
        #1;
        tb_oe    = 4'h0;
        mem_ce_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " bus"}, {28'd0, mem_sio}, 32'hF);
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        logic [3:0] din;
        for (int i = 7; i >= 0; i--) begin
            mclk_cycle({3'b000, b[i]}, 4'b0001, din);
        end
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        logic [3:0] din;
        mclk_cycle(b[7:4], 4'hF, din);
        mclk_cycle(b[3:0], 4'hF, din);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        logic [3:0] din;
        for (int i = 5; i >= 0; i--) begin
            mclk_cycle(a[i*4 +: 4], 4'hF, din);
        end
    endtask

    task automatic dummies();
        logic [3:0] din;
        for (int i = 0; i < WAIT_CYCLES; i++) begin
            mclk_cycle(4'h0, 4'h0, din);
        end
    endtask

    task automatic spi_cmd(input logic [7:0] b);
        $display("[TB] spi_cmd 0x%02h", b);
        ce_low();
        spi_byte(b);
        ce_high("spi_cmd");
    endtask

    task automatic qpi_cmd(input logic [7:0] b);
        $display("[TB] qpi_cmd 0x%02h", b);
        ce_low();
        qpi_byte(b);
        ce_high("qpi_cmd");
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
        logic [ADDR_BITS-1:0] idx;
        $display("[TB] qpi_write addr=0x%06h data=0x%02h 0x%02h", a, d0, d1);
        ce_low();
        qpi_byte(CMD_QPI_WRITE);
        qpi_addr(a);
        qpi_byte(d0);
        qpi_byte(d1);
        ce_high("qpi_write");
        idx = a[ADDR_BITS-1:0];
        model_mem[idx] = d0;
        idx = idx + 1'b1;
        model_mem[idx] = d1;
    endtask

    task automatic qpi_read(input logic [23:0] a, input int nbytes);
        logic [ADDR_BITS-1:0] idx;
        logic [3:0]           hi, lo;
        logic [7:0]           exp;
        $display("[TB] qpi_read addr=0x%06h bytes=%0d", a, nbytes);
        ce_low();
        qpi_byte(CMD_QPI_READ);
        qpi_addr(a);
        dummies();
        idx = a[ADDR_BITS-1:0];
        for (int k = 0; k < nbytes; k++) begin
            exp_q.push_back(model_mem[idx]);
            idx = idx + 1'b1;
            mclk_cycle(4'h0, 4'h0, hi);
            mclk_cycle(4'h0, 4'h0, lo);
            exp = exp_q.pop_front();
            check("qpi_rd hi", {28'd0, hi}, {28'd0, exp[7:4]});
            check("qpi_rd lo", {28'd0, lo}, {28'd0, exp[3:0]});
        end
        ce_high("qpi_read");
    endtask

    task automatic spi_read(input logic [23:0] a, input int nbytes);
        logic [ADDR_BITS-1:0] idx;
        logic [3:0]           din;
        logic [7:0]           got, exp;
        $display("[TB] spi_read addr=0x%06h bytes=%0d", a, nbytes);
        ce_low();
        spi_byte(CMD_SPI_READ);
        for (int i = 23; i >= 0; i--) begin
            mclk_cycle({3'b000, a[i]}, 4'b0001, din);
        end
        idx = a[ADDR_BITS-1:0];
        for (int k = 0; k < nbytes; k++) begin
`ifdef PSRAM_RESP_SPI_READ_EN
            exp_q.push_back(model_mem[idx]);
`else
            exp_q.push_back(8'hFF);
`endif
            idx = idx + 1'b1;
            for (int i = 7; i >= 0; i--) begin
                mclk_cycle(4'h0, 4'h0, din);
                got[i] = din[1];
            end
            exp = exp_q.pop_front();
            check("spi_rd byte", {24'd0, got}, {24'd0, exp});
        end
        ce_high("spi_read");
    endtask

    initial begin
        logic [3:0] din;

        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset released");
        check("reset qpi", {31'd0, qpi_mode}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset bus", {28'd0, mem_sio}, 32'hF);

        spi_cmd(CMD_QPI_ENTER);
        check("enter qpi", {31'd0, qpi_mode}, 32'd1);

        qpi_write(24'h000002, 8'hAB, 8'hCD);
        qpi_read(24'h000002, 2);

        qpi_write(24'h0003FF, 8'h12, 8'h34);
        qpi_read(24'h0003FF, 2);
        qpi_read(24'h000000, 1);

        // Abort after a single data nibble: the byte must not be written.
        qpi_write(24'h000010, 8'h77, 8'h88);
        $display("[TB] qpi_write_abort addr=0x000010 nibble=0x5");
        ce_low();
        qpi_byte(CMD_QPI_WRITE);
        qpi_addr(24'h000010);
        mclk_cycle(4'h5, 4'hF, din);
        ce_high("abort_wr");
        qpi_read(24'h000010, 2);

        // CE rise in the same cycle as the completing mem_clk rise.
        qpi_write(24'h000020, 8'h3C, 8'h5A);
        $display("[TB] qpi_write_same_edge addr=0x000020 data=0x96");
        ce_low();
        qpi_byte(CMD_QPI_WRITE);
        qpi_addr(24'h000020);
        mclk_cycle(4'h9, 4'hF, din);
        tb_dout = 4'h6;
        repeat (HALF) @(posedge clk);
        #1;
        mem_clk  = 1'b1;
        mem_ce_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("same_edge busy", {31'd0, busy}, 32'd0);
        repeat (HALF) @(posedge clk);
        #1;
        mem_clk = 1'b0;
        tb_oe   = 4'h0;
        repeat (HALF) @(posedge clk);
        #1;
        qpi_read(24'h000020, 1);

        // Abort in the middle of a read while the bus is being driven.
        $display("[TB] qpi_read_abort addr=0x000002");
        ce_low();
        qpi_byte(CMD_QPI_READ);
        qpi_addr(24'h000002);
        dummies();
        exp_q.push_back(model_mem[2]);
        mclk_cycle(4'h0, 4'h0, din);
        check("abort_rd hi", {28'd0, din}, {28'd0, exp_q.pop_front() >> 4});
        mclk_cycle(4'h0, 4'h0, din);
        ce_high("abort_rd");

        // Incomplete command: only one nibble of 0xF5.
        $display("[TB] qpi_cmd_partial nibble=0xF");
        ce_low();
        mclk_cycle(4'hF, 4'hF, din);
        ce_high("partial_cmd");
        check("partial qpi", {31'd0, qpi_mode}, 32'd1);

        qpi_cmd(CMD_QPI_EXIT);
        check("exit qpi", {31'd0, qpi_mode}, 32'd0);

        spi_read(24'h000002, 2);

        spi_cmd(CMD_QPI_ENTER);
        check("reenter qpi", {31'd0, qpi_mode}, 32'd1);
        qpi_cmd(CMD_RST_EN);
        qpi_cmd(CMD_RST);
        check("sw reset qpi", {31'd0, qpi_mode}, 32'd0);

        spi_cmd(CMD_QPI_ENTER);
        qpi_cmd(CMD_RST_EN);
        qpi_cmd(8'h00);
        qpi_cmd(CMD_RST);
        check("disarmed qpi", {31'd0, qpi_mode}, 32'd1);

        // Reset in the middle of a read.
        $display("[TB] qpi_read_reset addr=0x000002");
        ce_low();
        qpi_byte(CMD_QPI_READ);
        qpi_addr(24'h000002);
        dummies();
        mclk_cycle(4'h0, 4'h0, din);
        mclk_cycle(4'h0, 4'h0, din);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd busy", {31'd0, busy}, 32'd0);
        check("rst_rd qpi", {31'd0, qpi_mode}, 32'd0);
        check("rst_rd bus", {28'd0, mem_sio}, 32'hF);
        reset = 1'b0;
        ce_high("rst_rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
